// File: rtl/cmp_accumulator_pkg.sv
// cmp_accumulator_pkg: shared FSM state, decision encoding and default word size
package cmp_accumulator_pkg;
  localparam int NCHUNK_DEF = 4;
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  typedef enum logic [1:0] {NONE, GT, LT} dec_t;
endpackage

// File: rtl/cmp_chunk_counter.sv
// cmp_chunk_counter: counts accepted chunks; wraps to zero after the last one
module cmp_chunk_counter #(
  parameter int NCHUNK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = $clog2(NCHUNK);
  localparam logic [W-1:0] LAST = W'(NCHUNK - 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign tc = cnt_q == LAST;
  always_comb cnt_d = clr ? '0 : en ? (tc ? '0 : cnt_q + 1'b1) : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/cmp_accumulator.sv
// cmp_accumulator: folds MSB-first 2-bit chunk compare results into a word result
module cmp_accumulator
  import cmp_accumulator_pkg::*;
#(
  parameter int NCHUNK = NCHUNK_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic in_valid,
  input  logic g,
  input  logic l,
  input  logic e,
  output logic busy,
  output logic done,
  output logic gt,
  output logic lt,
  output logic eq,
  output logic err
);
  state_t state_q;
  dec_t   dec_q, dec_d;
  logic   acc_err_q, acc_err_d, onehot, tc;
  logic   busy_q, done_q, gt_q, lt_q, eq_q, err_q;
  cmp_chunk_counter #(.NCHUNK(NCHUNK)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(state_q == IDLE && start),
    .en (state_q == ACC && in_valid),
    .tc (tc)
  );
  assign onehot    = $countones({g, l, e}) == 1;
  assign acc_err_d = acc_err_q | ~onehot;
  // first onehot g/l wins; bad chunks never touch the decision
  assign dec_d = (onehot && dec_q == NONE) ? (g ? GT : l ? LT : NONE) : dec_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= IDLE;
      dec_q     <= NONE;
      acc_err_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
      eq_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q   <= ACC;
          busy_q    <= 1'b1;
          dec_q     <= NONE;
          acc_err_q <= 1'b0;
        end
        ACC: if (in_valid) begin
          dec_q     <= dec_d;
          acc_err_q <= acc_err_d;
          if (tc) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            gt_q    <= !acc_err_d && dec_d == GT;
            lt_q    <= !acc_err_d && dec_d == LT;
            eq_q    <= !acc_err_d && dec_d == NONE;
            err_q   <= acc_err_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign busy = busy_q;
  assign done = done_q;
  assign gt   = gt_q;
  assign lt   = lt_q;
  assign eq   = eq_q;
  assign err  = err_q;
endmodule

// File: tb/tb_cmp_accumulator.sv
// tb_cmp_accumulator: directed vectors with hand-computed word results
module tb_cmp_accumulator;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0, g = 1'b0, l = 1'b0, e = 1'b0;
  logic busy, done, gt, lt, eq, err;
  int checks = 0, failures = 0;
  cmp_accumulator #(.NCHUNK(4)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .g(g), .l(l), .e(e),
    .busy(busy), .done(done), .gt(gt), .lt(lt), .eq(eq), .err(err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic begin_word();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic chunk(input logic cg, input logic cl, input logic ce);
    {in_valid, g, l, e} = {1'b1, cg, cl, ce};
    tick();
    {in_valid, g, l, e} = 4'b0;
  endtask
  task automatic result(input string tag, input logic [3:0] exp_gtleqerr);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_res"}, {gt, lt, eq, err}, exp_gtleqerr);
  endtask
  initial begin
    #2;
    check("rst_outs", {busy, done, gt, lt, eq, err}, 6'b0);
    tick();
    rst = 1'b0;
    tick();
    check("idle_outs", {busy, done, gt, lt, eq, err}, 6'b0);
    // B4 vs B1: e e (gap) g l -> gt
    begin_word();
    check("s1_busy", busy, 1'b1);
    chunk(0, 0, 1);
    chunk(0, 0, 1);
    tick();
    check("s1_gap_busy", busy, 1'b1);
    chunk(1, 0, 0);
    check("s1_early_done", done, 1'b0);
    chunk(0, 1, 0);
    result("s1", 4'b1000);
    tick();
    check("s1_pulse", done, 1'b0);
    check("s1_hold", {gt, lt, eq, err}, 4'b1000);
    // equal words
    begin_word();
    repeat (4) chunk(0, 0, 1);
    result("s2", 4'b0010);
    tick();
    // early lt wins
    begin_word();
    chunk(0, 1, 0);
    repeat (3) chunk(1, 0, 0);
    result("s3", 4'b0100);
    tick();
    // bad chunk sets err, then clean equal word clears it
    begin_word();
    chunk(0, 0, 1);
    chunk(1, 1, 0);
    chunk(0, 0, 1);
    chunk(0, 0, 1);
    result("s4", 4'b0001);
    tick();
    check("s4_hold", {gt, lt, eq, err}, 4'b0001);
    begin_word();
    repeat (4) chunk(0, 0, 1);
    result("s4b", 4'b0010);
    tick();
    // reset mid-word
    begin_word();
    chunk(1, 0, 0);
    chunk(0, 0, 1);
    #3;
    rst = 1'b1;
    #1;
    check("s5_async", {busy, done, gt, lt, eq, err}, 6'b0);
    tick();
    check("s5_held", {busy, done, gt, lt, eq, err}, 6'b0);
    #3;
    rst = 1'b0;
    tick();
    check("s5_nodone", done, 1'b0);
    begin_word();
    repeat (4) chunk(0, 0, 1);
    result("s5", 4'b0010);
    tick();
    // start held through ACC and DONE; same-cycle in_valid ignored
    start = 1'b1;
    {in_valid, g, l, e} = 4'b1100;
    tick();
    {in_valid, g, l, e} = 4'b0;
    repeat (3) chunk(0, 0, 1);
    check("s6_cnt3", done, 1'b0);
    chunk(0, 0, 1);
    result("s6", 4'b0010);
    tick();
    start = 1'b0;
    check("s6_no_restart", busy, 1'b0);
    repeat (3) chunk(1, 0, 0);
    check("s6_idle_chunks", {busy, done}, 2'b00);
    begin_word();
    repeat (3) chunk(0, 1, 0);
    check("s6b_cnt3", done, 1'b0);
    chunk(0, 0, 1);
    result("s6b", 4'b0100);
    tick();
    check("s6b_end", {busy, done}, 2'b00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
